imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time program loader: the write side of the instruction memory, which the core only reads.
- Accepts a byte stream over a valid/ready handshake, typically from a UART receiver. The stream is a 4-byte word count followed by that many 32-bit instruction words.
- Each word is written into the instruction memory through a one-cycle write port.
- Holds the core in reset until a complete, valid image has been loaded.

Parameters:
- ADDR_W, 10, word-address width; capacity is 2^ADDR_W words (1024).
- DATA_W, 32, instruction word width; fixed at 4 bytes.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- start  in  1  one-cycle pulse that begins a new load; honoured in IDLE, DONE and ERR only.
- in_valid  in  1  byte available on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle; a transfer happens when in_valid && in_ready.
- mem_we  out  1  instruction-memory write strobe, one cycle per word.
- mem_addr  out  ADDR_W  word address; the top level drives byte address = mem_addr<<2.
- mem_wdata  out  DATA_W  assembled instruction word.
- cpu_rst  out  1  active-low reset to the core; high only in DONE.
- busy  out  1  high in HDR, DATA and WRITE.
- done  out  1  high in DONE.
- error  out  1  high in ERR.
- words_loaded  out  ADDR_W+1  number of words written in the current load.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. All outputs are 0: in_ready, mem_we, mem_addr, mem_wdata, cpu_rst, busy, done, error, words_loaded. Internal byte index, length and shift registers are also cleared.
- All outputs are registered except in_ready, which is decoded from state.
- IDLE: in_ready=0. start -> HDR.
- DONE / ERR: in_ready=0. start -> HDR. Entering HDR clears mem_addr, words_loaded, byte index and length.
- HDR: in_ready=1.
  - Accepted bytes fill the length register LSB-first.
  - After the 4th byte: len==0 -> DONE; len > 2^ADDR_W -> ERR; otherwise -> DATA.
- DATA: in_ready=1. Accepted bytes fill the word register LSB-first (byte0 = bits 7:0). After the 4th byte -> WRITE.
- WRITE: lasts exactly one cycle.
  - in_ready=0, mem_we=1, mem_addr = current address, mem_wdata = assembled word.
  - On exit, mem_addr and words_loaded increment.
  - If the incremented words_loaded == len -> DONE, else -> DATA.
- Latency: if the 4th data byte is accepted at edge t, mem_we is high in cycle t+1. The earliest next byte is accepted at edge t+2.
- in_valid with in_ready=0 (IDLE, WRITE, DONE, ERR) is not consumed. The source must hold the byte.
- Gaps in in_valid stall the FSM with no state change and no timeout.
- start while busy is ignored.
- start together with in_valid in DONE: the byte is not consumed; the header begins the following cycle.
- Wrap-around: len == 2^ADDR_W is legal. The final write goes to address 2^ADDR_W-1, and mem_addr then wraps to 0, which is harmless because the state is DONE.
- Reset mid-load: returns to IDLE immediately. Words already written stay in memory; cpu_rst stays low until a later load completes.
- cpu_rst=0 in every state except DONE.

Decomposition:
- Shared package imem_loader_pkg holds:
  - the state encoding (IDLE, HDR, DATA, WRITE, DONE, ERR);
  - HDR_BYTES=4 and BYTES_PER_WORD=4;
  - the default IMEM_ADDR_W=10.
- One sub-module, byte_packer: a 4-byte LSB-first shift assembler with a 2-bit index, a clear input and a "word complete" flag. It is used for both the header and the data words.

Test Plan:
- Reset: hold rst=0 while driving in_valid and start -> all outputs 0, state IDLE, no mem_we.
- Two-word load: start; bytes 02 00 00 00, 93 00 10 F0, 13 01 20 F0 -> writes addr0=F0100093 and addr1=F0200113; then done=1, cpu_rst=1, words_loaded=2, busy=0.
- Zero length: start; bytes 00 00 00 00 -> DONE one cycle after the 4th byte, mem_we never asserted, words_loaded=0.
- Oversize: start; bytes 01 04 00 00 (len=0x401, ADDR_W=10) -> error=1, no mem_we, cpu_rst=0. A following start and a valid image then load correctly from addr 0.
- Handshake stalls:
  - Randomise in_valid gaps and keep in_valid high through WRITE -> the byte is not consumed during WRITE, and the words still match.
  - mem_we is exactly one cycle per word, rising at t+1 after the 4th byte.
- Mid-load reset: assert rst=0 after 2 data bytes of word 1 -> IDLE with all outputs 0. A new load then writes starting at addr 0 with correct contents.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and sizing constants for the instruction-memory loader
package imem_loader_pkg;
  typedef enum logic [2:0] {IDLE, HDR, DATA, WRITE, DONE, ERR} state_e;
  localparam int HDR_BYTES = 4;
  localparam int BYTES_PER_WORD = 4;
  localparam int IMEM_ADDR_W = 10;
endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: LSB-first byte shift assembler; word shows the value including the byte presented now
module byte_packer #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic [7:0]            din,
  output logic [8*NBYTES-1:0]   word,
  output logic                  last
);
  localparam int IW = $clog2(NBYTES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);
  logic [IW-1:0] idx_q, idx_d;
  logic [8*NBYTES-1:0] sh_q, sh_d;
  always_comb begin
    word = {din, sh_q[8*NBYTES-1:8]};
    last = en && idx_q == LAST_IDX;
    idx_d = clr ? '0 : en ? idx_q + 1'b1 : idx_q;
    sh_d = clr ? '0 : en ? word : sh_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q <= '0;
      sh_q <= '0;
    end else begin
      idx_q <= idx_d;
      sh_q <= sh_d;
    end
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a length-prefixed byte stream into instruction memory and holds the core in reset until done
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);
  localparam int NB = (HDR_BYTES > BYTES_PER_WORD) ? HDR_BYTES : BYTES_PER_WORD;
  localparam logic [8*NB-1:0] CAP = (8*NB)'(1) << ADDR_W;
  state_e state_q, state_d;
  logic [ADDR_W:0] len_q, len_d, wl_q, wl_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic we_q, we_d, cpu_rst_q, cpu_rst_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic clr, pk_last;
  logic [8*NB-1:0] pk_word;
  byte_packer #(.NBYTES(NB)) u_packer (
    .clk(clk), .rst(rst), .clr(clr), .en(in_valid && in_ready),
    .din(in_data), .word(pk_word), .last(pk_last)
  );
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    wl_d = wl_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    clr = 1'b0;
    in_ready = state_q == HDR || state_q == DATA;
    case (state_q)
      IDLE, DONE, ERR: if (start) begin
        state_d = HDR;
        clr = 1'b1;
        len_d = '0;
        wl_d = '0;
        addr_d = '0;
      end
      HDR: if (pk_last) begin
        len_d = pk_word[ADDR_W:0];
        state_d = pk_word == '0 ? DONE : pk_word > CAP ? ERR : DATA;
      end
      DATA: if (pk_last) begin
        wdata_d = pk_word;
        state_d = WRITE;
      end
      WRITE: begin
        addr_d = addr_q + 1'b1;
        wl_d = wl_q + 1'b1;
        state_d = wl_d == len_q ? DONE : DATA;
      end
      default: state_d = IDLE;
    endcase
    we_d = state_d == WRITE;
    busy_d = state_d == HDR || state_d == DATA || state_d == WRITE;
    done_d = state_d == DONE;
    cpu_rst_d = state_d == DONE;
    err_d = state_d == ERR;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      len_q <= '0;
      wl_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      we_q <= 1'b0;
      cpu_rst_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      wl_q <= wl_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      we_q <= we_d;
      cpu_rst_q <= cpu_rst_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  assign mem_we = we_q;
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_rst = cpu_rst_q;
  assign busy = busy_q;
  assign done = done_q;
  assign error = err_q;
  assign words_loaded = wl_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for the instruction-memory loader
module tb_imem_loader;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_ready, mem_we, cpu_rst, busy, done, error;
  logic [9:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [10:0] words_loaded;
  int n_chk = 0;
  int n_fail = 0;
  int wr_n = 0;
  logic [31:0] img [4];

  imem_loader dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mem_we) wr_n <= wr_n + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wdat(input int w);
    return w < 4 ? img[w] : (32'hA500_0000 | 32'(w));
  endfunction

  task automatic send(input logic [7:0] b, input int gap);
    int i;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data = b;
    for (i = 0; i < 20 && !in_ready; i++) @(negedge clk);
    if (!in_ready) check("ready_timeout", {63'b0, in_ready}, 64'd1);
    @(negedge clk);
  endtask

  // start is pulsed together with the first header byte, which must not be consumed that cycle
  task automatic hdr_start(input logic [31:0] hdr);
    @(negedge clk);
    start = 1'b1;
    in_valid = 1'b1;
    in_data = hdr[7:0];
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < 4; b++) send(hdr[8*b +: 8], 0);
  endtask

  task automatic load(input logic [31:0] hdr, input int n, input int gapmax);
    logic [31:0] d;
    hdr_start(hdr);
    for (int w = 0; w < n; w++) begin
      d = wdat(w);
      for (int b = 0; b < 4; b++) send(d[8*b +: 8], int'($urandom_range(gapmax, 0)));
      check("we_lat", {63'b0, mem_we}, 64'd1);
      check("ready_in_write", {63'b0, in_ready}, 64'd0);
      check("waddr", {54'b0, mem_addr}, 64'(w % 1024));
      check("wdata", {32'b0, mem_wdata}, {32'b0, d});
    end
    in_valid = 1'b0;
    if (n > 0) @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, {63'b0, in_ready}, 64'd0);
    check({tag, "_we"}, {63'b0, mem_we}, 64'd0);
    check({tag, "_addr"}, {54'b0, mem_addr}, 64'd0);
    check({tag, "_wdata"}, {32'b0, mem_wdata}, 64'd0);
    check({tag, "_cpurst"}, {63'b0, cpu_rst}, 64'd0);
    check({tag, "_busy"}, {63'b0, busy}, 64'd0);
    check({tag, "_done"}, {63'b0, done}, 64'd0);
    check({tag, "_err"}, {63'b0, error}, 64'd0);
    check({tag, "_wl"}, {53'b0, words_loaded}, 64'd0);
  endtask

  initial begin
    int base;
    start = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hFF;
    repeat (3) @(negedge clk);
    check_idle_outputs("rst");
    check("rst_nowrite", 64'(wr_n), 64'd0);
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);

    img[0] = 32'hF010_0093;
    img[1] = 32'hF020_0113;
    base = wr_n;
    load(32'd2, 2, 0);
    check("two_writes", 64'(wr_n - base), 64'd2);
    check("two_done", {63'b0, done}, 64'd1);
    check("two_cpurst", {63'b0, cpu_rst}, 64'd1);
    check("two_wl", {53'b0, words_loaded}, 64'd2);
    check("two_busy", {63'b0, busy}, 64'd0);
    check("two_addr", {54'b0, mem_addr}, 64'd2);

    base = wr_n;
    load(32'd0, 0, 0);
    check("zero_done", {63'b0, done}, 64'd1);
    check("zero_wl", {53'b0, words_loaded}, 64'd0);
    @(negedge clk);
    check("zero_nowrite", 64'(wr_n - base), 64'd0);

    base = wr_n;
    load(32'h0000_0401, 0, 0);
    check("over_err", {63'b0, error}, 64'd1);
    check("over_cpurst", {63'b0, cpu_rst}, 64'd0);
    check("over_done", {63'b0, done}, 64'd0);
    @(negedge clk);
    check("over_nowrite", 64'(wr_n - base), 64'd0);
    img[0] = 32'h1234_5678;
    base = wr_n;
    load(32'd1, 1, 3);
    check("after_err_done", {63'b0, done}, 64'd1);
    check("after_err_err", {63'b0, error}, 64'd0);
    check("after_err_wl", {53'b0, words_loaded}, 64'd1);
    check("after_err_writes", 64'(wr_n - base), 64'd1);

    img[0] = 32'hDEAD_BEEF;
    img[1] = 32'h0000_0001;
    img[2] = 32'h8000_0000;
    img[3] = 32'hCAFE_F00D;
    base = wr_n;
    load(32'd4, 4, 4);
    check("stall_writes", 64'(wr_n - base), 64'd4);
    check("stall_wl", {53'b0, words_loaded}, 64'd4);
    check("stall_done", {63'b0, done}, 64'd1);

    hdr_start(32'd2);
    send(8'h11, 0);
    send(8'h22, 0);
    rst = 1'b0;
    #1;
    check_idle_outputs("midrst");
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    img[0] = 32'h0BAD_CAFE;
    base = wr_n;
    load(32'd1, 1, 1);
    check("midrst_writes", 64'(wr_n - base), 64'd1);
    check("midrst_done", {63'b0, done}, 64'd1);

    base = wr_n;
    load(32'd1024, 1024, 0);
    check("wrap_writes", 64'(wr_n - base), 64'd1024);
    check("wrap_wl", {53'b0, words_loaded}, 64'd1024);
    check("wrap_addr", {54'b0, mem_addr}, 64'd0);
    check("wrap_done", {63'b0, done}, 64'd1);
    check("wrap_cpurst", {63'b0, cpu_rst}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
